// File: rtl/alu_pipe_pkg.sv
// Shared widths, boolean constants and inside-opcode encodings for the alu_pipe execution unit.
package alu_pipe_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int ROB_TAG_WIDTH       = 4;
    localparam int INSIDE_OPCODE_WIDTH = 6;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [INSIDE_OPCODE_WIDTH-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_ADD   = 6'd5,
        OP_ADDI  = 6'd6,
        OP_SUB   = 6'd7,
        OP_XOR   = 6'd8,
        OP_XORI  = 6'd9,
        OP_OR    = 6'd10,
        OP_ORI   = 6'd11,
        OP_AND   = 6'd12,
        OP_ANDI  = 6'd13,
        OP_SLT   = 6'd14,
        OP_SLTI  = 6'd15,
        OP_SLTU  = 6'd16,
        OP_SLTIU = 6'd17,
        OP_SLL   = 6'd18,
        OP_SLLI  = 6'd19,
        OP_SRL   = 6'd20,
        OP_SRLI  = 6'd21,
        OP_SRA   = 6'd22,
        OP_SRAI  = 6'd23,
        OP_BEQ   = 6'd24,
        OP_BNE   = 6'd25,
        OP_BLT   = 6'd26,
        OP_BGE   = 6'd27,
        OP_BLTU  = 6'd28,
        OP_BGEU  = 6'd29
    } op_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Issue/result handshake bundle between the ALU reservation station, alu_pipe and the CDB arbiter.
interface alu_pipe_if
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int TAG_W  = ROB_TAG_WIDTH,
    parameter int OP_W   = INSIDE_OPCODE_WIDTH
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_rs1;
    logic [DATA_W-1:0] in_rs2;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] in_pc;
    logic [TAG_W-1:0]  in_tag;
    logic              in_flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_value;
    logic [TAG_W-1:0]  out_tag;
    logic              out_br_taken;
    logic [DATA_W-1:0] out_br_target;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_imm, in_pc, in_tag, in_flush, out_ready,
        input  in_ready, out_valid, out_value, out_tag, out_br_taken, out_br_target
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_imm, in_pc, in_tag, in_flush, out_ready,
        output in_ready, out_valid, out_value, out_tag, out_br_taken, out_br_target
    );
endinterface

// File: rtl/alu_core.sv
// Combinational RV32I integer/jump compute; branch resolution exists only when ALU_BRANCH_EN is defined.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int OP_W   = INSIDE_OPCODE_WIDTH
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] value,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target
);
    localparam int SH_W = $clog2(DATA_W);

    op_e               op_d;
    logic              use_imm;
    logic [DATA_W-1:0] b;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] pc_imm;

    assign op_d    = op_e'(op);
    assign use_imm = op_d inside {OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_SLTI, OP_SLTIU,
                                  OP_SLLI, OP_SRLI, OP_SRAI};
    assign b       = use_imm ? imm : rs2;
    assign shamt   = b[SH_W-1:0];
    assign pc_imm  = pc + imm;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        value     = '0;
        br_taken  = FALSE;
        br_target = '0;
        case (op_d)
            OP_LUI:            value = imm;
            OP_AUIPC:          value = pc_imm;
            OP_JAL: begin
                value = pc + DATA_W'(4);
`ifdef ALU_BRANCH_EN
                br_taken  = TRUE;
                br_target = pc_imm;
`endif
            end
            OP_JALR: begin
                value = pc + DATA_W'(4);
`ifdef ALU_BRANCH_EN
                br_taken  = TRUE;
                br_target = (rs1 + imm) & ~DATA_W'(1);
`endif
            end
            OP_ADD, OP_ADDI:   value = rs1 + b;
            OP_SUB:            value = rs1 - rs2;
            OP_XOR, OP_XORI:   value = rs1 ^ b;
            OP_OR, OP_ORI:     value = rs1 | b;
            OP_AND, OP_ANDI:   value = rs1 & b;
            OP_SLT, OP_SLTI:   value = DATA_W'($signed(rs1) < $signed(b));
            OP_SLTU, OP_SLTIU: value = DATA_W'(rs1 < b);
            OP_SLL, OP_SLLI:   value = rs1 << shamt;
            OP_SRL, OP_SRLI:   value = rs1 >> shamt;
            OP_SRA, OP_SRAI:   value = DATA_W'($signed(rs1) >>> shamt);
`ifdef ALU_BRANCH_EN
            // Conditional branches produce no rd value, only a resolution.
            OP_BEQ:  begin br_taken = (rs1 == rs2);                  br_target = pc_imm; end
            OP_BNE:  begin br_taken = (rs1 != rs2);                  br_target = pc_imm; end
            OP_BLT:  begin br_taken = ($signed(rs1) <  $signed(rs2)); br_target = pc_imm; end
            OP_BGE:  begin br_taken = ($signed(rs1) >= $signed(rs2)); br_target = pc_imm; end
            OP_BLTU: begin br_taken = (rs1 <  rs2);                  br_target = pc_imm; end
            OP_BGEU: begin br_taken = (rs1 >= rs2);                  br_target = pc_imm; end
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer execution unit: alu_core feeds stage 0, STAGES-deep valid/ready pipe to the CDB.
// Optional branch resolution is enabled with the ALU_BRANCH_EN macro.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int TAG_W  = ROB_TAG_WIDTH,
    parameter int OP_W   = INSIDE_OPCODE_WIDTH,
    parameter int STAGES = 2
) (
    input logic       clk,
    input logic       rst,
    input logic       rdy,
    alu_pipe_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] value;
        logic [TAG_W-1:0]  tag;
        logic              br_taken;
        logic [DATA_W-1:0] br_target;
    } stage_t;

    stage_t [STAGES-1:0] stage_q;
    stage_t              result;
    logic                adv;
    logic                accept;
    logic [DATA_W-1:0]   core_value;
    logic                core_taken;
    logic [DATA_W-1:0]   core_target;

    alu_core #(.DATA_W(DATA_W), .OP_W(OP_W)) u_core (
        .op        (bus.in_op),
        .rs1       (bus.in_rs1),
        .rs2       (bus.in_rs2),
        .imm       (bus.in_imm),
        .pc        (bus.in_pc),
        .value     (core_value),
        .br_taken  (core_taken),
        .br_target (core_target)
    );

    // The whole pipe moves as one; a held result stalls even the bubbles behind it.
    assign adv          = rdy & (~stage_q[STAGES-1].valid | bus.out_ready);
    assign bus.in_ready = adv & ~bus.in_flush & ~rst;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        result = '0;
        if (accept) result = {TRUE, core_value, bus.in_tag, core_taken, core_target};
    end

    // NOTE: state uses non-blocking assignments, and the pipe is fully reset since outputs must read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else if (rdy && bus.in_flush) begin
            for (int i = 0; i < STAGES; i++) stage_q[i].valid <= FALSE;
        end else if (adv) begin
            stage_q[0] <= result;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign bus.out_valid     = stage_q[STAGES-1].valid;
    assign bus.out_value     = stage_q[STAGES-1].value;
    assign bus.out_tag       = stage_q[STAGES-1].tag;
    assign bus.out_br_taken  = stage_q[STAGES-1].br_taken;
    assign bus.out_br_target = stage_q[STAGES-1].br_target;
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer execution unit for the out-of-order core. Accepts one issued micro-op per cycle from the ALU reservation station, computes the RV32I integer/jump result (and, optionally, branch resolution), and delivers result plus ROB tag to the common data bus after a configurable number of stages. Adds valid/ready flow control, ROB-flush cancellation and tag passthrough, which the single-cycle ALU lacks.

## Interface
- DATA_W, 32, operand/result width (power of two, ≥ 8)
- TAG_W, 4, ROB tag width
- OP_W, 6, inside-opcode width
- STAGES, 2, pipeline depth, legal 1..4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- in_valid  in  1  RS issues a micro-op
- in_ready  out  1  unit accepts this cycle
- in_op  in  OP_W  inside opcode
- in_rs1, in_rs2, in_imm, in_pc  in  DATA_W  operands, sign-extended immediate, instruction PC
- in_tag  in  TAG_W  destination ROB tag
- in_flush  in  1  ROB misprediction clear
- out_valid  out  1  result present
- out_ready  in  1  CDB grant
- out_value  out  DATA_W  rd value
- out_tag  out  TAG_W  ROB tag
- out_br_taken  out  1  branch/jump taken
- out_br_target  out  DATA_W  redirect target

## Operation
- Compute happens combinationally on inputs; result captured into stage 0; stages 1..STAGES-1 only carry {valid, value, tag, br_taken, br_target}. Output = last stage.
- Global advance adv = rdy & (!out_valid | out_ready). All stages shift together on adv; bubbles are not compressed.
- in_ready = adv & !in_flush. Accept = in_valid & in_ready.
- Ops: LUI imm; AUIPC pc+imm; JAL/JALR value pc+4; ADD/ADDI, SUB, XOR(I), OR(I), AND(I); SLT(I) signed, SLTU/SLTIU unsigned; SLL(I), SRL(I) logical, SRA(I) arithmetic ($signed). Shift amount = low log2(DATA_W) bits of rs2/imm only.
- Unknown opcode: completes normally with value 0, br_taken 0, br_target 0.
- All arithmetic modulo 2^DATA_W; no overflow flag.
- Flush: all stage valid bits cleared on the next edge (rdy high); input on the flush cycle is discarded; flush beats stall.
- rst: all valid bits and all outputs 0; in_ready is 0 during rst cycle.

## Timing
- Latency exactly STAGES cycles from accept to out_valid with no stall; throughput 1/cycle.
- out_valid held with stable value/tag until out_ready=1 sampled with rdy=1.
- Stall with out_valid=1, out_ready=0: in_ready=0, pipeline frozen, including leading bubbles.
- rdy=0: no state change, in_ready=0; outputs hold.
- Reset mid-stream: all in-flight ops dropped, nothing emitted afterwards.

## Configuration
- ALU_BRANCH_EN defined: BEQ/BNE/BLT/BGE/BLTU/BGEU set out_br_taken from rs1/rs2 compare, out_br_target = pc+imm, out_value 0; JAL taken=1, target pc+imm; JALR taken=1, target (rs1+imm) & ~1.
- Undefined: branch opcodes behave as unknown; JAL/JALR produce only pc+4; out_br_taken and out_br_target tied 0. Ports exist in both builds.

## Structure
- Shared defines header: DATA_WIDTH, ROB_TAG_WIDTH, INSIDE_OPCODE_WIDTH, all inside-opcode encodings, TRUE/FALSE.
- One sub-module: alu_core, purely combinational op decode and compute (value, br_taken, br_target); alu_pipe owns the stage registers and handshake.

## Test plan
- STAGES=2, ADDI rs1=0xFFFFFFFF imm=1 tag=3, out_ready=1 -> two cycles later out_valid=1, value 0x0, tag 3.
- SRA rs1=0x80000000 rs2=0x24 -> value 0xF8000000 (shift 4, sign fill); SRL same -> 0x08000000.
- Back-to-back ADD tags 1,2,3, out_ready low for 3 cycles after first output -> in_ready 0 while stalled, outputs emitted in order 1,2,3, none lost or duplicated.
- Two ops in flight, in_flush pulse with concurrent in_valid -> no out_valid afterward, flush-cycle op not accepted.
- ALU_BRANCH_EN: BLT rs1=-1 rs2=1 pc=0x100 imm=0x20 -> br_taken 1, target 0x120; BLTU same -> br_taken 0. JALR rs1=0x203 imm=0 pc=0x40 -> value 0x44, target 0x202.
- rdy low 5 cycles mid-stream, then rst during a stall -> state frozen while rdy low; after rst all outputs 0, in_ready 1 next cycle.
